game_tick_scheduler: RTL and testbench
======================================

// Module: game_tick_scheduler
// PURPOSE
//  Central scheduler for game-state update ticks; replaces the free-running per-object update dividers.
//  Generates block, ddaver and bullet update rates, queues each as a pending tick.
//  Releases pending ticks as 1-cycle strobes, round-robin, only while VGA is in blanking (no mid-frame tearing).
//  Owns the game phase FSM (title/play/pause/over). Sits between nunchuck driver/vga and the game state updater.
// PARAMETERS
//  CLK_HZ     50_000_000  system clock frequency
//  BLOCK_HZ   60          block update rate
//  DDAVER_HZ  1           ddaver update rate
//  BULLET_HZ  90          bullet update rate
//  PEND_W     2           width of each saturating pending-tick counter (max 3 queued)
// PORTS
//  clk           in   1  system clock
//  rst           in   1  synchronous active-low reset
//  in_blank      in   1  1 = vga outside active video (h or v blank)
//  pause_req     in   1  1-cycle pulse, toggles play/pause
//  restart_req   in   1  1-cycle pulse, start/restart game
//  game_over     in   1  level from state updater, player dead
//  tick_block    out  1  1-cycle update strobe, block
//  tick_ddaver   out  1  1-cycle update strobe, ddaver
//  tick_bullet   out  1  1-cycle update strobe, bullet
//  game_reset    out  1  1-cycle pulse: clear game state
//  phase         out  2  current phase_t
//  dropped_cnt   out  8  [TICK_DROP_CNT_EN only] saturating count of lost ticks
// BEHAVIOUR
//  Reset (rst==0 at clk edge): phase=PH_TITLE, all strobes/game_reset=0, rate counters=0, pending=0, rr ptr=block, dropped_cnt=0.
//  Rate gen i: DIV_i = CLK_HZ/RATE_i (integer truncation), counter 0..DIV_i-1; wrap when count==DIV_i-1.
//    Counter runs only in PH_PLAY; holds value in PH_PAUSE; cleared in PH_TITLE/PH_OVER.
//  Wrap -> pending_i += 1, saturating at 2**PEND_W-1. Wrap while pending_i is saturated drops the tick.
//  Grant: in PH_PLAY with in_blank==1, pick first nonzero pending in round-robin order block->ddaver->bullet,
//    starting at rr ptr; decrement it; rr ptr = grantee+1.
//    At most one grant per cycle. Strobe is registered: asserted the cycle after the grant cycle.
//  Wrap and grant on the same counter in the same cycle: net pending unchanged; no drop, even when saturated.
//  in_blank==0 or phase!=PH_PLAY: no grants. Pending is retained across pause, cleared on entering TITLE/OVER.
//  Phase FSM (registered; one transition per cycle):
//    TITLE --restart_req--> PLAY
//    PLAY  --game_over--> OVER
//    PLAY  --pause_req--> PAUSE
//    PAUSE --pause_req--> PLAY
//    OVER  --restart_req--> PLAY
//    game_over wins over pause_req in the same cycle. restart_req is ignored in PLAY/PAUSE.
//  game_reset=1 for exactly the cycle after a TITLE->PLAY or OVER->PLAY transition.
//    That transition also zeroes rate counters and pending.
//  rst asserted mid-operation: any in-flight strobe is suppressed on the next edge; full reset state.
// CONFIGURATION
//  TICK_DROP_CNT_EN defined: dropped_cnt port present.
//    +1 per dropped tick, saturates at 255; several drops in one cycle add their count (saturating).
//    Cleared on reset and on game_reset.
//  Not defined: port and logic absent; drops silent; all other behaviour identical.
// STRUCTURE
//  game_pkg: phase_t enum {PH_TITLE=0, PH_PLAY=1, PH_PAUSE=2, PH_OVER=3};
//    tick index constants TK_BLOCK=0, TK_DDAVER=1, TK_BULLET=2; NUM_TICKS=3.
//  Sub-module rate_tick_gen #(DIV, PEND_W): counter + saturating pending + drop flag.
//    Inputs: run, clear, grant. Instantiated 3x.
//  Top holds phase FSM, round-robin arbiter, output registers.
// TESTING  (CLK_HZ=1200 -> DIV block=20, ddaver=1200, bullet=13)
//  Reset, no restart_req: 2000 cycles -> phase=0, no strobes, game_reset never 1.
//  restart_req pulse, in_blank=1 -> game_reset=1 one cycle, phase=1.
//    tick_block every 20 cycles, tick_bullet every 13, tick_ddaver at 1200.
//  in_blank=0 for 100 cycles in PLAY, then 1 -> pending block=3 (sat), bullet=3 (sat);
//    exactly 6 strobes on consecutive cycles, alternating block/bullet; dropped_cnt>0 with TICK_DROP_CNT_EN.
//  Bullet and block wrap same cycle, in_blank=1 -> strobes on 2 consecutive cycles, order per rr ptr, no loss.
//  pause_req in PLAY -> phase=2, no strobes for 500 cycles;
//    pause_req again -> phase=1, counters resume from held values.
//  game_over and pause_req same cycle -> phase=3; restart_req -> phase=1, game_reset pulse, pending cleared;
//    rst=0 mid-strobe -> strobe low next cycle.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types for the game tick scheduler: phase encoding, tick indices and
// the round-robin pointer step used by the tick arbiter.
package game_pkg;

  typedef enum logic [1:0] {
    PH_TITLE = 2'd0,
    PH_PLAY  = 2'd1,
    PH_PAUSE = 2'd2,
    PH_OVER  = 2'd3
  } phase_t;

  localparam int TK_BLOCK  = 0;
  localparam int TK_DDAVER = 1;
  localparam int TK_BULLET = 2;
  localparam int NUM_TICKS = 3;

  // Pointer to the tick after idx, wrapping bullet back to block.
  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    return (idx == 2'(TK_BULLET)) ? 2'(TK_BLOCK) : idx + 2'd1;
  endfunction

endpackage

// File: rtl/rate_tick_gen.sv
// One update-rate divider feeding a saturating pending-tick counter.
// drop_o flags a wrap that found the pending counter already full.
module rate_tick_gen #(
  parameter int DIV    = 20,
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_i,
  input  logic              clear_i,
  input  logic              grant_i,
  output logic [PEND_W-1:0] pending_o,
  output logic              drop_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]     LAST     = CW'(DIV - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PEND_W-1:0] pend_q, pend_d;
  logic              wrap;

  always_comb begin
    cnt_d  = cnt_q;
    pend_d = pend_q;
    drop_o = 1'b0;
    wrap   = run_i && (cnt_q == LAST);
    if (clear_i) begin
      cnt_d  = '0;
      pend_d = '0;
    end else begin
      if (run_i) begin
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
      end
      // A wrap granted in the same cycle is a straight hand-over: no change, never a drop.
      if (wrap && !grant_i) begin
        if (pend_q == PEND_MAX) begin
          drop_o = 1'b1;
        end else begin
          pend_d = pend_q + 1'b1;
        end
      end else if (grant_i && !wrap) begin
        pend_d = pend_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      pend_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign pending_o = pend_q;

endmodule

// File: rtl/game_tick_scheduler.sv
// Game phase FSM plus blank-gated round-robin release of block/ddaver/bullet ticks.
// Define TICK_DROP_CNT_EN to add the saturating dropped_cnt output.
module game_tick_scheduler
  import game_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BLOCK_HZ  = 60,
  parameter int DDAVER_HZ = 1,
  parameter int BULLET_HZ = 90,
  parameter int PEND_W    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_blank,
  input  logic       pause_req,
  input  logic       restart_req,
  input  logic       game_over,
  output logic       tick_block,
  output logic       tick_ddaver,
  output logic       tick_bullet,
  output logic       game_reset,
  output logic [1:0] phase
`ifdef TICK_DROP_CNT_EN
  ,
  output logic [7:0] dropped_cnt
`endif
);

  localparam int DIV_BLOCK  = CLK_HZ / BLOCK_HZ;
  localparam int DIV_DDAVER = CLK_HZ / DDAVER_HZ;
  localparam int DIV_BULLET = CLK_HZ / BULLET_HZ;

  phase_t                 phase_q;
  logic                   game_reset_q;
  logic [NUM_TICKS-1:0]   tick_q;
  logic [1:0]             rr_q, rr_d;
  logic [NUM_TICKS-1:0]   grant, drop, pend_nz;
  logic [PEND_W-1:0]      pend_block, pend_ddaver, pend_bullet;
  logic                   run, clear;
  logic [2:0]             rr_sum;
  logic [1:0]             rr_idx;

  assign run   = (phase_q == PH_PLAY);
  assign clear = (phase_q == PH_TITLE) || (phase_q == PH_OVER);

  rate_tick_gen #(.DIV(DIV_BLOCK), .PEND_W(PEND_W)) u_gen_block (
    .clk(clk), .rst(rst), .run_i(run), .clear_i(clear), .grant_i(grant[TK_BLOCK]),
    .pending_o(pend_block), .drop_o(drop[TK_BLOCK])
  );

  rate_tick_gen #(.DIV(DIV_DDAVER), .PEND_W(PEND_W)) u_gen_ddaver (
    .clk(clk), .rst(rst), .run_i(run), .clear_i(clear), .grant_i(grant[TK_DDAVER]),
    .pending_o(pend_ddaver), .drop_o(drop[TK_DDAVER])
  );

  rate_tick_gen #(.DIV(DIV_BULLET), .PEND_W(PEND_W)) u_gen_bullet (
    .clk(clk), .rst(rst), .run_i(run), .clear_i(clear), .grant_i(grant[TK_BULLET]),
    .pending_o(pend_bullet), .drop_o(drop[TK_BULLET])
  );

  assign pend_nz[TK_BLOCK]  = |pend_block;
  assign pend_nz[TK_DDAVER] = |pend_ddaver;
  assign pend_nz[TK_BULLET] = |pend_bullet;

  // Grants only during blanking so the updater never changes state mid-frame.
  always_comb begin
    grant  = '0;
    rr_d   = rr_q;
    rr_sum = '0;
    rr_idx = '0;
    if (run && in_blank) begin
      for (int k = 0; k < NUM_TICKS; k++) begin
        rr_sum = {1'b0, rr_q} + 3'(k);
        rr_idx = (rr_sum >= 3'd3) ? 2'(rr_sum - 3'd3) : rr_sum[1:0];
        if ((grant == '0) && pend_nz[rr_idx]) begin
          grant[rr_idx] = 1'b1;
          rr_d          = rr_next(rr_idx);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q      <= PH_TITLE;
      game_reset_q <= 1'b0;
      tick_q       <= '0;
      rr_q         <= 2'(TK_BLOCK);
    end else begin
      tick_q       <= grant;
      rr_q         <= rr_d;
      game_reset_q <= 1'b0;
      case (phase_q)
        PH_TITLE, PH_OVER: begin
          if (restart_req) begin
            phase_q      <= PH_PLAY;
            game_reset_q <= 1'b1;
          end
        end
        PH_PLAY: begin
          if (game_over) begin
            phase_q <= PH_OVER;
          end else if (pause_req) begin
            phase_q <= PH_PAUSE;
          end
        end
        PH_PAUSE: begin
          if (pause_req) begin
            phase_q <= PH_PLAY;
          end
        end
        default: phase_q <= PH_TITLE;
      endcase
    end
  end

  assign tick_block  = tick_q[TK_BLOCK];
  assign tick_ddaver = tick_q[TK_DDAVER];
  assign tick_bullet = tick_q[TK_BULLET];
  assign game_reset  = game_reset_q;
  assign phase       = phase_q;

`ifdef TICK_DROP_CNT_EN
  logic [7:0] drop_cnt_q;
  logic [1:0] drop_sum;
  logic [8:0] drop_acc;

  assign drop_sum = {1'b0, drop[TK_BLOCK]} + {1'b0, drop[TK_DDAVER]} + {1'b0, drop[TK_BULLET]};
  assign drop_acc = {1'b0, drop_cnt_q} + {7'd0, drop_sum};

  // Cleared on the same edge that raises game_reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      drop_cnt_q <= '0;
    end else if (clear && restart_req) begin
      drop_cnt_q <= '0;
    end else begin
      drop_cnt_q <= drop_acc[8] ? 8'hFF : drop_acc[7:0];
    end
  end

  assign dropped_cnt = drop_cnt_q;
`else
  logic unused_drop;
  assign unused_drop = ^drop;
`endif

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Directed bench for game_tick_scheduler at CLK_HZ=1200 (block/ddaver/bullet DIV 20/1200/13).
// Honours TICK_DROP_CNT_EN for the dropped_cnt port.
module tb_game_tick_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_blank;
  logic       pause_req;
  logic       restart_req;
  logic       game_over;
  logic       tick_block, tick_ddaver, tick_bullet, game_reset;
  logic [1:0] phase;
`ifdef TICK_DROP_CNT_EN
  logic [7:0] dropped_cnt;
`endif

  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Expected {game_reset, tick_block, tick_ddaver, tick_bullet} per cycle.
  logic [3:0] exp_q[$];

  game_tick_scheduler #(
    .CLK_HZ(1200), .BLOCK_HZ(60), .DDAVER_HZ(1), .BULLET_HZ(90), .PEND_W(2)
  ) dut (
    .clk(clk), .rst(rst), .in_blank(in_blank), .pause_req(pause_req),
    .restart_req(restart_req), .game_over(game_over),
    .tick_block(tick_block), .tick_ddaver(tick_ddaver), .tick_bullet(tick_bullet),
    .game_reset(game_reset), .phase(phase)
`ifdef TICK_DROP_CNT_EN
    , .dropped_cnt(dropped_cnt)
`endif
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Driver tasks: every input change and sample happens 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [3:0] outs();
    return {game_reset, tick_block, tick_ddaver, tick_bullet};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_next(input string tag);
    logic [3:0] e;
    e = exp_q.pop_front();
    check(tag, {4'd0, outs()}, {4'd0, e});
  endtask

  initial begin
    rst         = 1'b0;
    in_blank    = 1'b1;
    pause_req   = 1'b0;
    restart_req = 1'b0;
    game_over   = 1'b0;

    // Reset state, then a long idle title screen.
    repeat (3) step();
    check("rst_outs", {4'd0, outs()}, 8'h00);
    check("rst_phase", {6'd0, phase}, 8'h00);
`ifdef TICK_DROP_CNT_EN
    check("rst_drop", dropped_cnt, 8'h00);
`endif
    rst = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      pause_req = (i == 1000);
      game_over = (i == 1500);
      step();
      check("title_idle", {2'd0, phase, outs()}, 8'h00);
    end
    pause_req = 1'b0;
    game_over = 1'b0;

    // Start play; strobe schedule over 1200+ cycles (block/bullet collide at
    // c260 multiples, block/ddaver at c1200; block always wins those since rr=block).
    cyc         = 0;
    restart_req = 1'b1;
    step();
    restart_req = 1'b0;
    check("start_greset", {7'd0, game_reset}, 8'h01);
    check("start_phase", {6'd0, phase}, 8'h01);
    for (int c = 2; c <= 1215; c++) begin
      bit b, u, d;
      b = (c >= 22) && ((c - 2) % 20 == 0);
      u = (((c - 2) >= 13) && ((c - 2) % 13 == 0) && ((c - 2) % 260 != 0)) ||
          (((c - 3) >= 260) && ((c - 3) % 260 == 0));
      d = (c == 1203);
      exp_q.push_back({1'b0, b, d, u});
    end
    while (exp_q.size() > 0) begin
      restart_req = (cyc == 500);
      step();
      check_next("play_sched");
    end
    restart_req = 1'b0;
    check("play_phase", {6'd0, phase}, 8'h01);

    // game_over beats pause_req.
    game_over = 1'b1;
    pause_req = 1'b1;
    step();
    game_over = 1'b0;
    pause_req = 1'b0;
    check("over_phase", {6'd0, phase}, 8'h03);
    for (int i = 0; i < 30; i++) begin
      step();
      check("over_quiet", {2'd0, phase, outs()}, 8'h30);
    end

    // Restart with blanking held low: pending saturates, 7 ticks dropped, then
    // six alternating strobes once blanking returns at c105.
    cyc         = 0;
    restart_req = 1'b1;
    in_blank    = 1'b0;
    step();
    restart_req = 1'b0;
    check("restart_greset", {7'd0, game_reset}, 8'h01);
    check("restart_phase", {6'd0, phase}, 8'h01);
`ifdef TICK_DROP_CNT_EN
    check("restart_drop", dropped_cnt, 8'h00);
`endif
    while (cyc < 112) begin
      if (cyc == 105) in_blank = 1'b1;
      step();
      if (cyc >= 106 && cyc <= 111) begin
        exp_q.push_back((cyc % 2 == 0) ? 4'b0100 : 4'b0001);
      end else begin
        exp_q.push_back(4'b0000);
      end
      check_next("burst");
    end
`ifdef TICK_DROP_CNT_EN
    check("drop_cnt", dropped_cnt, 8'h07);
`endif

    // Pause for 500 cycles (restart ignored), then resume from held counters.
    pause_req = 1'b1;
    step();
    pause_req = 1'b0;
    check("pause_phase", {6'd0, phase}, 8'h02);
    check("pause_outs", {4'd0, outs()}, 8'h00);
    while (cyc < 613) begin
      restart_req = (cyc == 300);
      step();
      check("paused", {2'd0, phase, outs()}, 8'h20);
    end
    restart_req = 1'b0;
    pause_req   = 1'b1;
    step();
    pause_req = 1'b0;
    check("resume_phase", {6'd0, phase}, 8'h01);
    check("resume_outs", {4'd0, outs()}, 8'h00);
    while (cyc < 623) begin
      step();
      exp_q.push_back((cyc == 620) ? 4'b0001 : (cyc == 623) ? 4'b0100 : 4'b0000);
      check_next("resume_sched");
    end

    // Reset while tick_block is high.
    rst = 1'b0;
    step();
    check("midrst_outs", {4'd0, outs()}, 8'h00);
    check("midrst_phase", {6'd0, phase}, 8'h00);
    rst = 1'b1;
    step();
    check("post_rst", {2'd0, phase, outs()}, 8'h00);
`ifdef TICK_DROP_CNT_EN
    check("post_rst_drop", dropped_cnt, 8'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
